dffram_2p: RTL and testbench
============================

# dffram_2p

Two-port, byte-writable flip-flop RAM and the parametrised successor to the single-port DFFRAM macro. Port 0 is read/write with per-byte write enables. Port 1 is an independent read-only port. Both ports share one clock and have registered read data. After reset, an internal sweep clears every word to zero before either port is accepted. The block serves as register-file and scratch-buffer storage wherever a simultaneous read and write are required.

## Interface
- `WSIZE`, 4: word width in bytes; data width is `WSIZE*8`.
- `BANKS`, 4: number of banks; power of two, 1..16.
- `BANK_WORDS`, 32: words per bank; power of two, 8..64.
- Derived, not overridable: `DEPTH = BANKS*BANK_WORDS`; `AWIDTH = $clog2(DEPTH)`.

- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `EN0` in 1: port 0 enable.
- `WE0` in `WSIZE`: port 0 byte write enables; bit i covers bits `[8i+7:8i]`.
- `A0` in `AWIDTH`: port 0 word address.
- `Di0` in `WSIZE*8`: port 0 write data.
- `Do0` out `WSIZE*8`: port 0 registered read data.
- `EN1` in 1: port 1 read enable.
- `A1` in `AWIDTH`: port 1 word address.
- `Do1` out `WSIZE*8`: port 1 registered read data.
- `READY` out 1: high once the clear sweep is done and the ports are live.

## Operation
- Address split: `A[AWIDTH-1:$clog2(BANK_WORDS)]` selects the bank; the low bits select the word within the bank.
- FSM states are CLEAR and RUN.
- CLEAR:
  - Entered on every cycle with `RST`=1.
  - A counter `clr_addr` of width `AWIDTH` starts at 0 and writes all-zero to word `clr_addr` each cycle with `RST`=0.
  - After writing word `DEPTH-1`, the FSM moves to RUN.
- RUN persists until `RST` is asserted again.
- While in CLEAR, `EN0`, `EN1` and `WE0` are ignored.
- Reset values:
  - `Do0`=0, `Do1`=0, `READY`=0, state=CLEAR, `clr_addr`=0.
  - Array contents are not directly reset; they are zeroed only by the sweep.
- Reset mid-sweep: the sweep restarts from address 0. Words already cleared stay 0.
- Port 0 in RUN with `EN0`=1:
  - `WE0`≠0: bytes with `WE0[i]`=1 are written at the edge; other bytes are unchanged. `Do0` holds its previous value (no read on a write cycle).
  - `WE0`=0: word `A0` is read and `Do0` updates at the edge.
- `EN0`=0: no access; `Do0` holds.
- Port 1 in RUN with `EN1`=1: word `A1` is read and `Do1` updates at the edge. With `EN1`=0, `Do1` holds.
- Collision (port 0 writes and port 1 reads the same address in one cycle): behaviour is set by the Configuration macro below.
- Port 0 and port 1 addressing different banks or different words never interact.

## Timing
- Read latency is 1 cycle on both ports. Address and enable are sampled at edge N; `Do` is valid after edge N and stable until the next enabled read.
- A write at edge N is visible to any read sampled at edge N+1 or later.
- Sweep duration: `READY` rises after the edge that writes word `DEPTH-1`. That is exactly `DEPTH` cycles after the first edge with `RST`=0 (128 cycles at defaults). The first accepted access is at the following edge.
- No backpressure and no handshake exists beyond `READY`. Accesses presented while `READY`=0 are dropped silently.

## Configuration
- Macro: `DFFRAM_2P_BYPASS_EN`.
- Defined: on a collision, `Do1` returns the merged word: new bytes where `WE0[i]`=1, old bytes elsewhere (write-first).
- Undefined: on a collision, `Do1` returns the pre-write contents (read-first). There is no bypass mux in the port 1 path.
- Port 0 behaviour is identical in both builds.

## Test plan
- **Reset sweep:** pulse `RST` for 2 cycles, then count cycles. Required:
  - `READY` rises exactly 128 cycles later.
  - Reads of 0x00, 0x45 and 0x7F return 0x00000000.
  - `Do0`/`Do1` are 0 during reset.
- **Full and byte writes:**
  - Write 0x00←AA0055BB (`WE0`=1111), then 0x00←00330000 (`WE0`=0100). Required: read of 0x00 returns AA3355BB.
  - Repeat at bank 1, address 0x20. Required: 0x20 returns AA3355BB and 0x00 is unaffected.
- **Concurrent ports:**
  - Preload 0x11←11111111 and 0x22←22222222.
  - In one cycle, port 0 writes 0x11←CAFEF00D while port 1 reads 0x22. Required: `Do1`=22222222.
  - Next cycle, port 1 reads 0x11. Required: `Do1`=CAFEF00D.
- **Collision:** preload 0x05←AA0055CC, then port 0 writes 0x05←00003300 (`WE0`=0010) while port 1 reads 0x05. Required:
  - `Do1`=AA0033CC with the macro defined.
  - `Do1`=AA0055CC without it.
  - A later read of 0x05 returns AA0033CC in both builds.
- **Reset mid-sweep and gating:**
  - Assert `RST` at sweep cycle 60, release, and confirm `READY` arrives after 128 further cycles.
  - Issue a write 0x7F←FFFFFFFF while `READY`=0. Required: a later read of 0x7F returns 0.
  - With `EN1`=0, `Do1` holds its last value.

Source files
------------

// File: rtl/dffram_2p_if.sv
// Port bundle for dffram_2p: read/write port 0, read-only port 1 and the READY flag.
// The master drives addresses, enables and write data; the slave is the RAM.
interface dffram_2p_if #(
    parameter int WSIZE  = 4,
    parameter int AWIDTH = 7
);
    logic                  EN0;
    logic [WSIZE-1:0]      WE0;
    logic [AWIDTH-1:0]     A0;
    logic [WSIZE*8-1:0]    Di0;
    logic [WSIZE*8-1:0]    Do0;
    logic                  EN1;
    logic [AWIDTH-1:0]     A1;
    logic [WSIZE*8-1:0]    Do1;
    logic                  READY;

    modport master (
        output EN0, WE0, A0, Di0, EN1, A1,
        input  Do0, Do1, READY
    );

    modport slave (
        input  EN0, WE0, A0, Di0, EN1, A1,
        output Do0, Do1, READY
    );
endinterface

// File: rtl/dffram_2p.sv
// Two-port banked flip-flop RAM: port 0 byte-writable read/write, port 1 read-only.
// Build option: DFFRAM_2P_BYPASS_EN makes port 1 write-first on a same-address collision.
module dffram_2p #(
    parameter int  WSIZE      = 4,
    parameter int  BANKS      = 4,
    parameter int  BANK_WORDS = 32,
    localparam int DEPTH      = BANKS * BANK_WORDS,
    localparam int AWIDTH     = $clog2(DEPTH)
) (
    input  logic       CLK,
    input  logic       RST,
    dffram_2p_if.slave bus
);
    localparam int DW   = WSIZE * 8;
    localparam int WW   = $clog2(BANK_WORDS);
    localparam int BSW  = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int NSEL = 1 << BSW;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   clr_addr_q, clr_addr_d;

    logic                live;
    logic                wr_en;
    logic [AWIDTH-1:0]   wr_addr;
    logic [DW-1:0]       wr_data;
    logic [WSIZE-1:0]    wr_be;
    logic                rd0_en, rd1_en;

    logic [BSW-1:0]      wr_bank, rd0_bank, rd1_bank;
    logic [WW-1:0]       wr_word, rd0_word, rd1_word;
    logic [BSW-1:0]      sel0_q, sel1_q;
    logic [DW-1:0]       rd0_data [NSEL];
    logic [DW-1:0]       rd1_data [NSEL];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == AWIDTH'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    // The sweep borrows the port 0 write path, so the banks see one write port.
    always_comb begin
        live    = (state_q == RUN) && !RST;
        wr_en   = 1'b0;
        wr_addr = bus.A0;
        wr_data = bus.Di0;
        wr_be   = bus.WE0;
        if (state_q == CLEAR) begin
            wr_en   = !RST;
            wr_addr = clr_addr_q;
            wr_data = '0;
            wr_be   = '1;
        end else begin
            wr_en = live && bus.EN0 && (bus.WE0 != '0);
        end
        rd0_en = live && bus.EN0 && (bus.WE0 == '0);
        rd1_en = live && bus.EN1;
    end

    assign wr_bank  = BSW'(wr_addr >> WW);
    assign rd0_bank = BSW'(bus.A0 >> WW);
    assign rd1_bank = BSW'(bus.A1 >> WW);
    assign wr_word  = wr_addr[WW-1:0];
    assign rd0_word = bus.A0[WW-1:0];
    assign rd1_word = bus.A1[WW-1:0];

    // Bank select is remembered so Do holds when the port is idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel0_q <= '0;
            sel1_q <= '0;
        end else begin
            if (rd0_en) sel0_q <= rd0_bank;
            if (rd1_en) sel1_q <= rd1_bank;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_bank
            if (gi < BANKS) begin : g_mem
                logic [DW-1:0] mem [BANK_WORDS];
                logic [DW-1:0] rd0_q, rd1_q;
                logic          bank_wr, bank_rd0, bank_rd1;

                assign bank_wr  = wr_en  && (wr_bank  == BSW'(gi));
                assign bank_rd0 = rd0_en && (rd0_bank == BSW'(gi));
                assign bank_rd1 = rd1_en && (rd1_bank == BSW'(gi));

                always_ff @(posedge CLK) begin
                    for (int b = 0; b < WSIZE; b++) begin
                        if (bank_wr && wr_be[b]) begin
                            mem[wr_word][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end

                always_ff @(posedge CLK) begin
                    if (RST) begin
                        rd0_q <= '0;
                    end else if (bank_rd0) begin
                        rd0_q <= mem[rd0_word];
                    end
                end

`ifdef DFFRAM_2P_BYPASS_EN
                logic [DW-1:0] merged;
                logic          wr_hit;

                assign wr_hit = bank_wr && (wr_word == rd1_word);

                always_comb begin
                    merged = mem[rd1_word];
                    for (int b = 0; b < WSIZE; b++) begin
                        if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end

                always_ff @(posedge CLK) begin
                    if (RST) begin
                        rd1_q <= '0;
                    end else if (bank_rd1) begin
                        rd1_q <= wr_hit ? merged : mem[rd1_word];
                    end
                end
`else
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        rd1_q <= '0;
                    end else if (bank_rd1) begin
                        rd1_q <= mem[rd1_word];
                    end
                end
`endif

                assign rd0_data[gi] = rd0_q;
                assign rd1_data[gi] = rd1_q;
            end else begin : g_pad
                assign rd0_data[gi] = '0;
                assign rd1_data[gi] = '0;
            end
        end
    endgenerate

    assign bus.Do0   = rd0_data[sel0_q];
    assign bus.Do1   = rd1_data[sel1_q];
    assign bus.READY = (state_q == RUN);

endmodule

// File: tb/tb_dffram_2p.sv
// Directed bench for dffram_2p at default geometry (4 banks x 32 words x 32 bits).
// Define DFFRAM_2P_BYPASS_EN for both RTL and bench to check the write-first build.
module tb_dffram_2p;
    logic clk;
    logic rst;

    dffram_2p_if #(.WSIZE(4), .AWIDTH(7)) bus ();

    dffram_2p #(.WSIZE(4), .BANKS(4), .BANK_WORDS(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en0;
        logic [3:0]  we0;
        logic [6:0]  a0;
        logic [31:0] di0;
        logic        en1;
        logic [6:0]  a1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.EN0 = 1'b0;
        bus.WE0 = 4'h0;
        bus.A0  = 7'h00;
        bus.Di0 = 32'h0;
        bus.EN1 = 1'b0;
        bus.A1  = 7'h00;
    endtask

    // Counts edges from reset release to READY while hammering both ports with
    // accesses that must be dropped.
    task automatic sweep(input string name);
        int n;
        n = 0;
        do begin
            bus.EN0 = 1'b1;
            bus.WE0 = 4'hF;
            bus.Di0 = 32'hFFFF_FFFF;
            bus.A0  = (n < 64) ? 7'h7F : 7'h00;
            bus.EN1 = 1'b1;
            bus.A1  = 7'h7F;
            tick();
            n++;
        end while (!bus.READY && n < 300);
        idle();
        $display("sweep %s: READY after %0d cycles", name, n);
        check({name, "_cycles"}, 32'(n), 32'd128);
        check({name, "_do1_idle"}, bus.Do1, 32'h0);
    endtask

    task automatic read_both(input string name, input logic [6:0] a0, input logic [6:0] a1,
                             input logic [31:0] e0, input logic [31:0] e1);
        bus.EN0 = 1'b1; bus.WE0 = 4'h0; bus.A0 = a0;
        bus.EN1 = 1'b1; bus.A1 = a1;
        tick();
        idle();
        $display("read %s: A0=%02h Do0=%08h A1=%02h Do1=%08h", name, a0, bus.Do0, a1, bus.Do1);
        check({name, "_do0"}, bus.Do0, e0);
        check({name, "_do1"}, bus.Do1, e1);
    endtask

    initial begin
        logic [31:0] coll;
`ifdef DFFRAM_2P_BYPASS_EN
        coll = 32'hAA00_33CC;
`else
        coll = 32'hAA00_55CC;
`endif
        vecs[0]  = '{1'b1, 4'h0, 7'h00, 32'h0,          1'b1, 7'h45, 32'h0,          32'h0};
        vecs[1]  = '{1'b1, 4'h0, 7'h7F, 32'h0,          1'b1, 7'h7F, 32'h0,          32'h0};
        vecs[2]  = '{1'b1, 4'hF, 7'h00, 32'hAA00_55BB,  1'b0, 7'h00, 32'h0,          32'h0};
        vecs[3]  = '{1'b1, 4'h4, 7'h00, 32'h0033_0000,  1'b0, 7'h00, 32'h0,          32'h0};
        vecs[4]  = '{1'b1, 4'h0, 7'h00, 32'h0,          1'b1, 7'h00, 32'hAA33_55BB,  32'hAA33_55BB};
        vecs[5]  = '{1'b1, 4'hF, 7'h20, 32'hAA00_55BB,  1'b0, 7'h00, 32'hAA33_55BB,  32'hAA33_55BB};
        vecs[6]  = '{1'b1, 4'h4, 7'h20, 32'h0033_0000,  1'b0, 7'h00, 32'hAA33_55BB,  32'hAA33_55BB};
        vecs[7]  = '{1'b1, 4'h0, 7'h20, 32'h0,          1'b1, 7'h01, 32'hAA33_55BB,  32'h0};
        vecs[8]  = '{1'b1, 4'h0, 7'h00, 32'h0,          1'b1, 7'h20, 32'hAA33_55BB,  32'hAA33_55BB};
        vecs[9]  = '{1'b1, 4'hF, 7'h11, 32'h1111_1111,  1'b0, 7'h00, 32'hAA33_55BB,  32'hAA33_55BB};
        vecs[10] = '{1'b1, 4'hF, 7'h22, 32'h2222_2222,  1'b0, 7'h00, 32'hAA33_55BB,  32'hAA33_55BB};
        vecs[11] = '{1'b1, 4'hF, 7'h11, 32'hCAFE_F00D,  1'b1, 7'h22, 32'hAA33_55BB,  32'h2222_2222};
        vecs[12] = '{1'b1, 4'h0, 7'h22, 32'h0,          1'b1, 7'h11, 32'h2222_2222,  32'hCAFE_F00D};
        vecs[13] = '{1'b1, 4'hF, 7'h05, 32'hAA00_55CC,  1'b0, 7'h00, 32'h2222_2222,  32'hCAFE_F00D};
        vecs[14] = '{1'b1, 4'h2, 7'h05, 32'h0000_3300,  1'b1, 7'h05, 32'h2222_2222,  coll};
        vecs[15] = '{1'b1, 4'h0, 7'h05, 32'h0,          1'b1, 7'h05, 32'hAA00_33CC,  32'hAA00_33CC};
        vecs[16] = '{1'b0, 4'hF, 7'h00, 32'h0,          1'b0, 7'h11, 32'hAA00_33CC,  32'hAA00_33CC};
        vecs[17] = '{1'b1, 4'h0, 7'h00, 32'h0,          1'b0, 7'h22, 32'hAA33_55BB,  32'hAA00_33CC};
        vecs[18] = '{1'b1, 4'h0, 7'h11, 32'h0,          1'b1, 7'h00, 32'hCAFE_F00D,  32'hAA33_55BB};

        idle();
        rst = 1'b1;
        tick();
        tick();
        check("rst_do0", bus.Do0, 32'h0);
        check("rst_do1", bus.Do1, 32'h0);
        check("rst_ready", 32'(bus.READY), 32'h0);

        // Interrupt the first sweep at cycle 60 and restart it.
        rst = 1'b0;
        repeat (60) tick();
        check("mid_sweep_ready", 32'(bus.READY), 32'h0);
        rst = 1'b1;
        tick();
        check("mid_rst_ready", 32'(bus.READY), 32'h0);
        rst = 1'b0;
        sweep("restart");

        for (int i = 0; i < NVEC; i++) begin
            bus.EN0 = vecs[i].en0;
            bus.WE0 = vecs[i].we0;
            bus.A0  = vecs[i].a0;
            bus.Di0 = vecs[i].di0;
            bus.EN1 = vecs[i].en1;
            bus.A1  = vecs[i].a1;
            tick();
            $display("vec %0d: EN0=%0b WE0=%h A0=%02h Di0=%08h EN1=%0b A1=%02h -> Do0=%08h Do1=%08h",
                     i, vecs[i].en0, vecs[i].we0, vecs[i].a0, vecs[i].di0,
                     vecs[i].en1, vecs[i].a1, bus.Do0, bus.Do1);
            check($sformatf("vec%0d_do0", i), bus.Do0, vecs[i].exp0);
            check($sformatf("vec%0d_do1", i), bus.Do1, vecs[i].exp1);
        end
        idle();

        // Reset from RUN: outputs clear immediately, the sweep wipes stored data.
        rst = 1'b1;
        tick();
        check("run_rst_do0", bus.Do0, 32'h0);
        check("run_rst_do1", bus.Do1, 32'h0);
        check("run_rst_ready", 32'(bus.READY), 32'h0);
        rst = 1'b0;
        sweep("rerun");
        read_both("post_00_45", 7'h00, 7'h45, 32'h0, 32'h0);
        read_both("post_7f_05", 7'h7F, 7'h05, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
